// File: rtl/mix_columns.sv
// mix_columns: AES MixColumns on a column-major 128-bit state, one registered stage.
// Define MIX_COLUMNS_INV_EN to add an inv input selecting InvMixColumns.
module mix_columns (
  input  logic         clk,
  input  logic         rst_n,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv,
`endif
  input  logic [127:0] a,
  output logic [127:0] b
);
  logic [127:0] w_mix;
  logic [127:0] r_b;
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction
  // 2*x0 ^ 3*x1 folds into xtime(x0 ^ x1) ^ x1
  function automatic logic [31:0] fwd(input logic [31:0] col);
    logic [7:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = col;
    return {xt(x3 ^ x0) ^ x0 ^ x1 ^ x2,
            xt(x2 ^ x3) ^ x3 ^ x0 ^ x1,
            xt(x1 ^ x2) ^ x2 ^ x3 ^ x0,
            xt(x0 ^ x1) ^ x1 ^ x2 ^ x3};
  endfunction
`ifdef MIX_COLUMNS_INV_EN
  // k selects which of 8,4,2,1 multiples of v are summed
  function automatic logic [7:0] mul(input logic [7:0] v, input logic [3:0] k);
    logic [7:0] v2, v4, v8;
    v2 = xt(v);
    v4 = xt(v2);
    v8 = xt(v4);
    return (k[3] ? v8 : 8'h00) ^ (k[2] ? v4 : 8'h00) ^ (k[1] ? v2 : 8'h00) ^ (k[0] ? v : 8'h00);
  endfunction
  function automatic logic [31:0] rev(input logic [31:0] col);
    logic [7:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = col;
    return {mul(x0, 4'hb) ^ mul(x1, 4'hd) ^ mul(x2, 4'h9) ^ mul(x3, 4'he),
            mul(x0, 4'hd) ^ mul(x1, 4'h9) ^ mul(x2, 4'he) ^ mul(x3, 4'hb),
            mul(x0, 4'h9) ^ mul(x1, 4'he) ^ mul(x2, 4'hb) ^ mul(x3, 4'hd),
            mul(x0, 4'he) ^ mul(x1, 4'hb) ^ mul(x2, 4'hd) ^ mul(x3, 4'h9)};
  endfunction
`endif
  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
`ifdef MIX_COLUMNS_INV_EN
      w_mix[32*c +: 32] = inv ? rev(a[32*c +: 32]) : fwd(a[32*c +: 32]);
`else
      w_mix[32*c +: 32] = fwd(a[32*c +: 32]);
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_b <= '0;
    else        r_b <= w_mix;
  end
  assign b = r_b;
endmodule

// File: tb/tb_mix_columns.sv
// tb_mix_columns: directed checks of the registered MixColumns stage against hand vectors and a GF model.
module tb_mix_columns;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] a = '0;
  logic [127:0] b;
  int           n_cmp = 0;
  int           n_bad = 0;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv = 1'b0;
  logic [127:0] t, r;
`endif
  logic [127:0] x1, x2;
  always #5 clk = ~clk;
  mix_columns dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef MIX_COLUMNS_INV_EN
    .inv  (inv),
`endif
    .a    (a),
    .b    (b)
  );
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p ^= s;
      s = s[7] ? ((s << 1) ^ 8'h1b) : (s << 1);
    end
    return p;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv_sel);
    logic [7:0] row0 [4];
    logic [7:0] acc;
    logic [127:0] o;
    row0 = inv_sel ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(s[8*(k+4*c) +: 8], row0[(k-rr)&3]);
        o[8*(rr+4*c) +: 8] = acc;
      end
    return o;
  endfunction
  task automatic check(input string tag, input logic [127:0] exp);
    n_cmp++;
    assert (b === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, b, exp);
    end
  endtask
  task automatic step(input logic [127:0] v, input string tag, input logic [127:0] exp);
    a = v;
    @(negedge clk);
    check(tag, exp);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    a = 128'h1a96de77f1d2027f895339453b87db49;
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", 128'h0);
    rst_n = 1'b1;
    step(128'h1a96de77f1d2027f895339453b87db49, "fips", 128'he5b06b1ba8cae7dbac5a4b1bf1ca4d58);
    step({4{32'h455313db}}, "col_db13", {4{32'hbca14d8e}});
    step({4{32'h5c220af2}}, "col_f20a", {4{32'h9d58dc9f}});
    step(128'h0, "zero", 128'h0);
    step({4{32'h01010101}}, "ones", {4{32'h01010101}});
    step({16{8'hc6}}, "c6", {16{8'hc6}});
    a = {4{32'h455313db}};
    #2 rst_n = 1'b0;
    #1 check("async_rst", 128'h0);
    @(negedge clk);
    check("rst_held", 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", {4{32'hbca14d8e}});
    for (int i = 0; i < 8; i++) begin
      x1 = {$urandom, $urandom, $urandom, $urandom};
      step(x1, $sformatf("pipe%0d", i), model(x1, 1'b0));
    end
    x1 = {$urandom, $urandom, $urandom, $urandom};
    x2 = ~x1;
    a = x1;
    @(posedge clk);
    #1 a = x2;
    #2 check("mid_change", model(x1, 1'b0));
    @(negedge clk);
    check("mid_hold", model(x1, 1'b0));
    @(negedge clk);
    check("mid_next", model(x2, 1'b0));
`ifdef MIX_COLUMNS_INV_EN
    inv = 1'b1;
    step({4{32'hbca14d8e}}, "inv_col", {4{32'h455313db}});
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'b0;
      step(r, "rt_fwd", model(r, 1'b0));
      t = b;
      inv = 1'b1;
      step(t, "rt_inv", r);
    end
    inv = 1'b0;
    step(128'h1a96de77f1d2027f895339453b87db49, "inv0_fips", 128'he5b06b1ba8cae7dbac5a4b1bf1ca4d58);
    step({4{32'h5c220af2}}, "inv0_col", {4{32'h9d58dc9f}});
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
